// File: rtl/dual_port_fill_ram.sv
// dual_port_fill_ram
//   Synchronous single-array RAM with a CPU read/write port (A), a read-only
//   fetch port (B) and a fill engine that writes one word per cycle over a
//   contiguous, wrapping address range.
//   Optional feature macro: RAM_READ_FORWARD_EN
//     defined   -> a port-B read that hits the address being written in the
//                  same cycle returns the new write data
//     undefined -> that port-B read returns the old word
//   Port A is always read-first. Memory contents are not affected by reset.
module dual_port_fill_ram #(
    parameter int unsigned AddrBits = 16,
    parameter int unsigned DataBits = 8
) (
    input  logic                clk,
    input  logic                reset,

    input  logic                aWriteEnabled,
    input  logic [AddrBits-1:0] aAddress,
    input  logic [DataBits-1:0] aDataIn,
    output logic [DataBits-1:0] aDataOut,
    output logic                aReady,

    input  logic                bReadEnabled,
    input  logic [AddrBits-1:0] bAddress,
    output logic [DataBits-1:0] bDataOut,
    output logic                bValid,

    input  logic                fillStart,
    input  logic [AddrBits-1:0] fillBase,
    input  logic [AddrBits:0]   fillCount,
    input  logic [DataBits-1:0] fillValue,
    output logic                fillBusy,
    output logic                fillDone
);

    localparam int unsigned Depth = 1 << AddrBits;

    localparam logic [AddrBits-1:0] PtrOne = AddrBits'(1);
    localparam logic [AddrBits:0]   CntOne = (AddrBits + 1)'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } fill_state_t;

    fill_state_t state;
    fill_state_t state_next;

    // Storage array; deliberately has no reset so it maps onto block RAM.
    logic [DataBits-1:0] mem [0:Depth-1];

    // Fill engine registers, captured on the start cycle.
    logic [AddrBits-1:0] fill_ptr;
    logic [AddrBits:0]   fill_remaining;
    logic [DataBits-1:0] fill_value;
    logic                fill_load;

    // Single shared write port: fill owns it while busy, otherwise port A.
    logic                wr_en;
    logic [AddrBits-1:0] wr_addr;
    logic [DataBits-1:0] wr_data;

    // Port-B read data after optional write forwarding.
    logic [DataBits-1:0] b_read_data;
    logic                b_forward;

    assign aReady   = (state != FILL);
    assign fillBusy = (state == FILL);
    assign fillDone = (state == DONE);

    // State register; reset aborts any fill without a completion pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and fill-parameter capture strobe.
    always_comb begin
        state_next = state;
        fill_load  = 1'b0;
        case (state)
            IDLE: begin
                if (fillStart) begin
                    if (fillCount != '0) begin
                        state_next = FILL;
                        fill_load  = 1'b1;
                    end else begin
                        state_next = DONE;
                    end
                end
            end
            FILL: begin
                if (fill_remaining == CntOne) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Fill pointer, remaining count and pattern; pointer wraps naturally.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fill_ptr       <= '0;
            fill_remaining <= '0;
            fill_value     <= '0;
        end else if (fill_load) begin
            fill_ptr       <= fillBase;
            fill_remaining <= fillCount;
            fill_value     <= fillValue;
        end else if (state == FILL) begin
            fill_ptr       <= fill_ptr + PtrOne;
            fill_remaining <= fill_remaining - CntOne;
        end
    end

    // Write-port arbitration; port A is locked out (and dropped) during fill.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = aAddress;
        wr_data = aDataIn;
        if (state == FILL) begin
            wr_en   = 1'b1;
            wr_addr = fill_ptr;
            wr_data = fill_value;
        end else if (aWriteEnabled) begin
            wr_en   = 1'b1;
        end
    end

    // Memory write.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

`ifdef RAM_READ_FORWARD_EN
    assign b_forward = wr_en && (wr_addr == bAddress);
`else
    assign b_forward = 1'b0;
`endif

    // Port-B read source selection.
    always_comb begin
        b_read_data = mem[bAddress];
        if (b_forward) begin
            b_read_data = wr_data;
        end
    end

    // Port A registered read, read-first against its own write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            aDataOut <= '0;
        end else begin
            aDataOut <= mem[aAddress];
        end
    end

    // Port B registered read with a one-cycle valid strobe; data holds when idle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bDataOut <= '0;
            bValid   <= 1'b0;
        end else if (bReadEnabled) begin
            bDataOut <= b_read_data;
            bValid   <= 1'b1;
        end else begin
            bValid   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dual_port_fill_ram.sv
// tb_dual_port_fill_ram
//   Directed test of dual_port_fill_ram with AddrBits=16, DataBits=8.
//   Expected port-B forwarding result follows RAM_READ_FORWARD_EN.
module tb_dual_port_fill_ram;

    logic        clk;
    logic        reset;
    logic        aWriteEnabled;
    logic [15:0] aAddress;
    logic [7:0]  aDataIn;
    logic [7:0]  aDataOut;
    logic        aReady;
    logic        bReadEnabled;
    logic [15:0] bAddress;
    logic [7:0]  bDataOut;
    logic        bValid;
    logic        fillStart;
    logic [15:0] fillBase;
    logic [16:0] fillCount;
    logic [7:0]  fillValue;
    logic        fillBusy;
    logic        fillDone;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    dual_port_fill_ram #(
        .AddrBits(16),
        .DataBits(8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .aWriteEnabled(aWriteEnabled),
        .aAddress     (aAddress),
        .aDataIn      (aDataIn),
        .aDataOut     (aDataOut),
        .aReady       (aReady),
        .bReadEnabled (bReadEnabled),
        .bAddress     (bAddress),
        .bDataOut     (bDataOut),
        .bValid       (bValid),
        .fillStart    (fillStart),
        .fillBase     (fillBase),
        .fillCount    (fillCount),
        .fillValue    (fillValue),
        .fillBusy     (fillBusy),
        .fillDone     (fillDone)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_a(input logic [15:0] addr, input logic [7:0] data);
        aWriteEnabled = 1'b1;
        aAddress      = addr;
        aDataIn       = data;
        tick();
        aWriteEnabled = 1'b0;
    endtask

    task automatic read_a(input logic [15:0] addr, output logic [7:0] data);
        aAddress = addr;
        tick();
        data = aDataOut;
    endtask

    task automatic start_fill(input logic [15:0] base, input logic [16:0] count,
                              input logic [7:0] value);
        fillStart = 1'b1;
        fillBase  = base;
        fillCount = count;
        fillValue = value;
        tick();
        fillStart = 1'b0;
        fillBase  = 16'h0000;
        fillCount = '0;
        fillValue = 8'h00;
    endtask

    // Waits out a running fill; returns busy cycles seen and fillDone pulses seen.
    task automatic wait_fill(output int unsigned busy_cycles, output int unsigned dones);
        busy_cycles = 0;
        dones       = 0;
        while (fillBusy && busy_cycles < 500) begin
            busy_cycles++;
            tick();
            if (fillDone) dones++;
        end
        tick();
        if (fillDone) dones++;
    endtask

    logic [7:0]  rd;
    logic [7:0]  exp_fwd;
    int unsigned n;
    int unsigned d;

    initial begin
        reset         = 1'b0;
        aWriteEnabled = 1'b0;
        aAddress      = 16'h0000;
        aDataIn       = 8'h00;
        bReadEnabled  = 1'b0;
        bAddress      = 16'h0000;
        fillStart     = 1'b0;
        fillBase      = 16'h0000;
        fillCount     = '0;
        fillValue     = 8'h00;

        // Reset state
        tick();
        tick();
        check("rst_aDataOut", 32'(aDataOut), 32'h0);
        check("rst_bDataOut", 32'(bDataOut), 32'h0);
        check("rst_bValid",   32'(bValid),   32'h0);
        check("rst_fillBusy", 32'(fillBusy), 32'h0);
        check("rst_fillDone", 32'(fillDone), 32'h0);
        check("rst_aReady",   32'(aReady),   32'h1);
        reset = 1'b1;
        tick();

        // Port A write/read and read-first behaviour
        write_a(16'h0010, 8'h11);
        write_a(16'h0010, 8'h5A);
        check("a_read_first", 32'(aDataOut), 32'h11);
        read_a(16'h0010, rd);
        check("a_read_back", 32'(rd), 32'h5A);

        // Port B read, then idle hold
        bReadEnabled = 1'b1;
        bAddress     = 16'h0010;
        tick();
        check("b_valid_on", 32'(bValid),   32'h1);
        check("b_data",     32'(bDataOut), 32'h5A);
        bReadEnabled = 1'b0;
        bAddress     = 16'h0020;
        tick();
        check("b_valid_off", 32'(bValid),   32'h0);
        check("b_data_hold", 32'(bDataOut), 32'h5A);

        // Fill 32 words of 0x00 at 0x2000, port A write dropped during fill
        write_a(16'h2000, 8'h99);
        write_a(16'h201F, 8'h55);
        write_a(16'h2020, 8'h77);
        write_a(16'h0001, 8'h12);
        start_fill(16'h2000, 17'd32, 8'h00);
        check("fill_busy_start", 32'(fillBusy), 32'h1);
        check("fill_aready_low", 32'(aReady),   32'h0);
        aWriteEnabled = 1'b1;
        aAddress      = 16'h0001;
        aDataIn       = 8'hEE;
        tick();
        aWriteEnabled = 1'b0;
        n = 1;
        d = 0;
        if (fillDone) d++;
        while (fillBusy && n < 500) begin
            n++;
            tick();
            if (fillDone) d++;
        end
        tick();
        if (fillDone) d++;
        check("fill32_busy_cycles", 32'(n), 32'd32);
        check("fill32_done_pulses", 32'(d), 32'd1);
        check("fill32_aready_back", 32'(aReady), 32'h1);
        read_a(16'h2000, rd); check("fill32_first", 32'(rd), 32'h00);
        read_a(16'h201F, rd); check("fill32_last",  32'(rd), 32'h00);
        read_a(16'h2020, rd); check("fill32_after", 32'(rd), 32'h77);
        read_a(16'h0001, rd); check("fill32_a_drop", 32'(rd), 32'h12);

        // Wrapping fill from 0xFFFE
        write_a(16'hFFFD, 8'h44);
        write_a(16'h0002, 8'h33);
        start_fill(16'hFFFE, 17'd4, 8'hAA);
        wait_fill(n, d);
        check("wrap_busy_cycles", 32'(n), 32'd4);
        check("wrap_done_pulses", 32'(d), 32'd1);
        read_a(16'hFFFE, rd); check("wrap_fffe", 32'(rd), 32'hAA);
        read_a(16'hFFFF, rd); check("wrap_ffff", 32'(rd), 32'hAA);
        read_a(16'h0000, rd); check("wrap_0000", 32'(rd), 32'hAA);
        read_a(16'h0001, rd); check("wrap_0001", 32'(rd), 32'hAA);
        read_a(16'h0002, rd); check("wrap_0002", 32'(rd), 32'h33);
        read_a(16'hFFFD, rd); check("wrap_fffd", 32'(rd), 32'h44);

        // Zero-count fill: done one cycle after start, no writes
        start_fill(16'h0010, 17'd0, 8'hFF);
        check("zero_done",  32'(fillDone), 32'h1);
        check("zero_busy",  32'(fillBusy), 32'h0);
        tick();
        check("zero_done_end", 32'(fillDone), 32'h0);
        read_a(16'h0010, rd); check("zero_no_write", 32'(rd), 32'h5A);

        // Reset during fill: first 10 words written, rest untouched
        write_a(16'h3009, 8'h01);
        write_a(16'h300A, 8'h02);
        write_a(16'h300B, 8'h03);
        write_a(16'h3063, 8'h04);
        start_fill(16'h3000, 17'd100, 8'hC3);
        for (int i = 0; i < 10; i++) tick();
        check("abort_busy_before", 32'(fillBusy), 32'h1);
        reset = 1'b0;
        #1;
        check("abort_busy_now",  32'(fillBusy), 32'h0);
        check("abort_aready",    32'(aReady),   32'h1);
        d = 0;
        for (int i = 0; i < 2; i++) begin
            tick();
            if (fillDone) d++;
        end
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (fillDone) d++;
        end
        check("abort_no_done", 32'(d), 32'd0);
        check("abort_idle",    32'(fillBusy), 32'h0);
        read_a(16'h3000, rd); check("abort_w0",  32'(rd), 32'hC3);
        read_a(16'h3009, rd); check("abort_w9",  32'(rd), 32'hC3);
        read_a(16'h300A, rd); check("abort_w10", 32'(rd), 32'h02);
        read_a(16'h300B, rd); check("abort_w11", 32'(rd), 32'h03);
        read_a(16'h3063, rd); check("abort_w99", 32'(rd), 32'h04);

        // Same-cycle port-A write and port-B read of one address
        write_a(16'h0040, 8'h11);
`ifdef RAM_READ_FORWARD_EN
        exp_fwd = 8'h3C;
`else
        exp_fwd = 8'h11;
`endif
        aWriteEnabled = 1'b1;
        aAddress      = 16'h0040;
        aDataIn       = 8'h3C;
        bReadEnabled  = 1'b1;
        bAddress      = 16'h0040;
        tick();
        aWriteEnabled = 1'b0;
        bReadEnabled  = 1'b0;
        check("coll_b_data",  32'(bDataOut), 32'(exp_fwd));
        check("coll_b_valid", 32'(bValid),   32'h1);
        check("coll_a_first", 32'(aDataOut), 32'h11);
        read_a(16'h0040, rd); check("coll_commit", 32'(rd), 32'h3C);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
